// File: rtl/mapa_seletor_seq.sv
// Map selector for the display path: holds the active map index, steps it on
// next/prev/load/auto-preview requests and drives the registered map word.
module mapa_seletor_seq #(
    parameter int WIDTH   = 7,
    parameter int N_MAPAS = 4,
    parameter int SEL_W   = 2,
    parameter int PERIODO = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MAPAS*WIDTH-1:0]   mapas,
    input  logic                       prox,
    input  logic                       ant,
    input  logic                       carrega,
    input  logic [SEL_W-1:0]           idx_in,
    input  logic                       modo_auto,
    input  logic                       trava,
    output logic [SEL_W-1:0]           sel_out,
    output logic [WIDTH-1:0]           mapa_out,
    output logic                       troca,
    output logic                       travado
);

    // state   | meaning
    // LIVRE   | manual selection only
    // AUTO    | manual selection plus periodic preview rotation
    // TRAVADO | selection frozen, requests dropped, tick counter held

    localparam int CNT_W = (PERIODO > 2) ? $clog2(PERIODO) : 1;

    typedef enum logic [1:0] {
        LIVRE   = 2'd0,
        AUTO    = 2'd1,
        TRAVADO = 2'd2
    } estado_t;

    estado_t            estado;
    estado_t            estado_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               mudou;
    logic [WIDTH-1:0]   banco [N_MAPAS];

    logic               ativo;
    logic               carga_ok;
    logic               tick;
    logic               manual;
    logic [SEL_W-1:0]   idx_prox;
    logic [SEL_W-1:0]   idx_ant;
    logic [SEL_W-1:0]   idx_nxt;

    for (genvar i = 0; i < N_MAPAS; i++) begin : g_banco
        assign banco[i] = mapas[i*WIDTH +: WIDTH];
    end

    // Requests are dropped both while locked and on the cycle the lock arrives.
    assign ativo    = !trava && (estado != TRAVADO);
    assign carga_ok = {1'b0, idx_in} < (SEL_W+1)'(N_MAPAS);
    assign tick     = (cnt == CNT_W'(PERIODO - 1));
    assign idx_prox = (sel_out == SEL_W'(N_MAPAS - 1)) ? '0 : sel_out + SEL_W'(1);
    assign idx_ant  = (sel_out == '0) ? SEL_W'(N_MAPAS - 1) : sel_out - SEL_W'(1);

    always_comb begin
        idx_nxt = sel_out;
        manual  = 1'b0;
        if (ativo) begin
            if (carrega) begin
                if (carga_ok) begin
                    idx_nxt = idx_in;
                    manual  = 1'b1;
                end
            end else if (prox && !ant) begin
                idx_nxt = idx_prox;
                manual  = 1'b1;
            end else if (ant && !prox) begin
                idx_nxt = idx_ant;
                manual  = 1'b1;
            end else if (!prox && !ant && estado == AUTO && tick) begin
                idx_nxt = idx_prox;
            end
        end
    end

    always_comb begin
        estado_nxt = estado;
        if (trava) begin
            estado_nxt = TRAVADO;
        end else begin
            case (estado)
                TRAVADO: estado_nxt = modo_auto ? AUTO : LIVRE;
                LIVRE:   estado_nxt = modo_auto ? AUTO : LIVRE;
                AUTO:    estado_nxt = modo_auto ? AUTO : LIVRE;
                default: estado_nxt = LIVRE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado   <= LIVRE;
            sel_out  <= '0;
            mapa_out <= '0;
            mudou    <= 1'b0;
            troca    <= 1'b0;
            travado  <= 1'b0;
            cnt      <= '0;
        end else begin
            estado   <= estado_nxt;
            sel_out  <= idx_nxt;
            mudou    <= (idx_nxt != sel_out);
            troca    <= mudou;
            mapa_out <= banco[sel_out];
            travado  <= (estado_nxt == TRAVADO);
            // Counter runs only in AUTO; it keeps its value across a lock.
            if (estado == LIVRE && modo_auto && !trava) begin
                cnt <= '0;
            end else if (estado == AUTO && ativo) begin
                if (manual || tick) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mapa_seletor_seq.sv
// Directed bench for mapa_seletor_seq: a 4-map instance and a 3-map instance
// share stimulus so the non-power-of-two wrap and range check are exercised.
module tb_mapa_seletor_seq;

    logic        clk;
    logic        rst_n;
    logic        prox;
    logic        ant;
    logic        carrega;
    logic [1:0]  idx_in;
    logic        modo_auto;
    logic        trava;
    logic [27:0] mapas4;
    logic [20:0] mapas3;

    logic [1:0]  sel4;
    logic [6:0]  mapa4;
    logic        troca4;
    logic        travado4;
    logic [1:0]  sel3;
    logic [6:0]  mapa3;
    logic        troca3;
    logic        travado3;

    int total = 0;
    int bad   = 0;

    logic [6:0] mp [4];

    typedef struct {
        logic       p;
        logic       a;
        logic       c;
        logic [1:0] idx;
        logic [1:0] e4;
        logic [1:0] e3;
    } vec_t;

    vec_t tv [11];

    assign mapas3 = mapas4[20:0];

    mapa_seletor_seq #(.WIDTH(7), .N_MAPAS(4), .SEL_W(2), .PERIODO(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mapas(mapas4), .prox(prox), .ant(ant),
        .carrega(carrega), .idx_in(idx_in), .modo_auto(modo_auto), .trava(trava),
        .sel_out(sel4), .mapa_out(mapa4), .troca(troca4), .travado(travado4)
    );

    mapa_seletor_seq #(.WIDTH(7), .N_MAPAS(3), .SEL_W(2), .PERIODO(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .mapas(mapas3), .prox(prox), .ant(ant),
        .carrega(carrega), .idx_in(idx_in), .modo_auto(modo_auto), .trava(trava),
        .sel_out(sel3), .mapa_out(mapa3), .troca(troca3), .travado(travado3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prox    = 1'b0;
        ant     = 1'b0;
        carrega = 1'b0;
        idx_in  = 2'd0;
    endtask

    initial begin
        logic [1:0] prev4;
        logic [1:0] prev3;

        mp[0] = 7'b1000001;
        mp[1] = 7'b1100011;
        mp[2] = 7'b1110111;
        mp[3] = 7'b1111001;
        mapas4 = {mp[3], mp[2], mp[1], mp[0]};

        //            p     a     c     idx   e4    e3
        tv[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd2};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 2'd2};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 2'd2};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2};
        tv[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd2};
        tv[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0};

        rst_n     = 1'b0;
        modo_auto = 1'b0;
        trava     = 1'b0;
        idle_inputs();

        // reset state
        step();
        step();
        chk("rst_sel", 32'(sel4), 32'd0);
        chk("rst_mapa", 32'(mapa4), 32'd0);
        chk("rst_troca", 32'(troca4), 32'd0);
        chk("rst_travado", 32'(travado4), 32'd0);
        chk("rst_sel3", 32'(sel3), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_mapa", 32'(mapa4), 32'(mp[0]));
        chk("rel_troca", 32'(troca4), 32'd0);
        chk("rel_sel", 32'(sel4), 32'd0);
        chk("rel_mapa3", 32'(mapa3), 32'(mp[0]));

        // table: one request cycle, then one idle cycle to see mapa_out/troca
        prev4 = 2'd0;
        prev3 = 2'd0;
        for (int i = 0; i < 11; i++) begin
            prox    = tv[i].p;
            ant     = tv[i].a;
            carrega = tv[i].c;
            idx_in  = tv[i].idx;
            step();
            idle_inputs();
            chk($sformatf("v%0d_sel4", i), 32'(sel4), 32'(tv[i].e4));
            chk($sformatf("v%0d_sel3", i), 32'(sel3), 32'(tv[i].e3));
            step();
            chk($sformatf("v%0d_mapa4", i), 32'(mapa4), 32'(mp[tv[i].e4]));
            chk($sformatf("v%0d_troca4", i), 32'(troca4), 32'(tv[i].e4 != prev4));
            chk($sformatf("v%0d_mapa3", i), 32'(mapa3), 32'(mp[tv[i].e3]));
            chk($sformatf("v%0d_troca3", i), 32'(troca3), 32'(tv[i].e3 != prev3));
            prev4 = tv[i].e4;
            prev3 = tv[i].e3;
        end

        // back-to-back prox from index 0
        prox = 1'b1;
        step();
        chk("b2b_sel1", 32'(sel4), 32'd1);
        chk("b2b_troca1", 32'(troca4), 32'd0);
        step();
        chk("b2b_sel2", 32'(sel4), 32'd2);
        chk("b2b_troca2", 32'(troca4), 32'd1);
        chk("b2b_mapa2", 32'(mapa4), 32'(mp[1]));
        step();
        chk("b2b_sel3", 32'(sel4), 32'd3);
        chk("b2b_troca3", 32'(troca4), 32'd1);
        chk("b2b_mapa3", 32'(mapa4), 32'(mp[2]));
        prox = 1'b0;
        step();
        chk("b2b_troca4", 32'(troca4), 32'd1);
        chk("b2b_mapa4", 32'(mapa4), 32'(mp[3]));
        step();
        chk("b2b_troca5", 32'(troca4), 32'd0);

        // bank content change reaches mapa_out one edge later
        mapas4[27:21] = 7'b0101010;
        step();
        chk("bank_new", 32'(mapa4), 32'h2a);
        mapas4[27:21] = mp[3];
        step();
        chk("bank_restore", 32'(mapa4), 32'(mp[3]));

        // auto rotation, PERIODO=4
        carrega = 1'b1;
        idx_in  = 2'd0;
        step();
        idle_inputs();
        chk("auto_pre", 32'(sel4), 32'd0);
        modo_auto = 1'b1;
        step();
        chk("auto_enter", 32'(sel4), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                chk($sformatf("auto_s%0d_c%0d", s, c), 32'(sel4),
                    (c == 4) ? 32'(s % 4) : 32'(s - 1));
            end
        end

        // prox mid-period restarts the count
        step();
        step();
        prox = 1'b1;
        step();
        prox = 1'b0;
        chk("mid_prox", 32'(sel4), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("mid_c%0d", c), 32'(sel4), (c == 4) ? 32'd2 : 32'd1);
        end

        // lock for 10 cycles with requests; counter frozen at 1
        step();
        for (int i = 0; i < 10; i++) begin
            trava   = 1'b1;
            prox    = (i % 2 == 0);
            carrega = (i % 3 == 0);
            idx_in  = 2'd0;
            step();
            chk($sformatf("lk%0d_travado", i), 32'(travado4), 32'd1);
            chk($sformatf("lk%0d_sel", i), 32'(sel4), 32'd2);
            chk($sformatf("lk%0d_troca", i), 32'(troca4), 32'd0);
        end
        trava = 1'b0;
        idle_inputs();
        prox = 1'b1;
        step();
        prox = 1'b0;
        chk("rel_travado", 32'(travado4), 32'd0);
        chk("rel_prox_ign", 32'(sel4), 32'd2);
        step();
        chk("res_c1", 32'(sel4), 32'd2);
        step();
        chk("res_c2", 32'(sel4), 32'd2);
        step();
        chk("res_tick", 32'(sel4), 32'd3);
        step();
        chk("res_troca", 32'(troca4), 32'd1);
        chk("res_mapa", 32'(mapa4), 32'(mp[3]));

        // reset mid-rotation
        rst_n = 1'b0;
        step();
        chk("mrst_sel", 32'(sel4), 32'd0);
        chk("mrst_mapa", 32'(mapa4), 32'd0);
        chk("mrst_troca", 32'(troca4), 32'd0);
        chk("mrst_travado", 32'(travado4), 32'd0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
